// File: rtl/mem_io_responder_pkg.sv
// Shared address map and IO register decode for the CPU memory/IO responder.
package mem_io_responder_pkg;

    localparam logic [17:0] IO_BASE      = 18'h30000;
    localparam logic [17:0] IO_UART_ADDR = 18'h30000;
    localparam logic [17:0] IO_CLK_ADDR  = 18'h30004;
    localparam logic [1:0]  IO_SEL       = IO_BASE[17:16];

    typedef enum logic [2:0] {
        IoNone,
        IoUart,
        IoClk0,
        IoClk1,
        IoClk2,
        IoClk3
    } io_reg_e;

    function automatic logic is_io(input logic [17:0] addr);
        return addr[17:16] == IO_SEL;
    endfunction

    function automatic io_reg_e io_decode(input logic [17:0] addr);
        case (addr)
            IO_UART_ADDR:         return IoUart;
            IO_CLK_ADDR:          return IoClk0;
            IO_CLK_ADDR + 18'd1:  return IoClk1;
            IO_CLK_ADDR + 18'd2:  return IoClk2;
            IO_CLK_ADDR + 18'd3:  return IoClk3;
            default:              return IoNone;
        endcase
    endfunction

endpackage

// File: rtl/mem_io_responder_tx_fifo.sv
// Byte-wide circular tx FIFO with registered almost-full flag and overflow pulse.
module mem_io_tx_fifo #(
    parameter int unsigned Depth      = 8,
    parameter int unsigned FullMargin = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       push_i,
    input  logic [7:0] push_data_i,
    input  logic       pop_i,
    output logic       valid_o,
    output logic [7:0] data_o,
    output logic       almost_full_o,
    output logic       overflow_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [7:0]      mem_q [Depth];
    logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0] count_q, count_d;
    logic            almost_full_q;
    logic            full, do_push, do_pop;

    always_comb begin
        full    = count_q == CntW'(Depth);
        do_pop  = pop_i && (count_q != '0);
        // A pop in the same cycle frees the slot, so a push to a full FIFO still lands.
        do_push = push_i && (!full || do_pop);
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CntW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            almost_full_q <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            count_q       <= count_d;
            almost_full_q <= count_d >= CntW'(Depth - FullMargin);
        end
    end

    assign valid_o       = count_q != '0;
    assign data_o        = mem_q[rd_ptr_q];
    assign almost_full_o = almost_full_q;
    assign overflow_o    = push_i && full && !do_pop;

endmodule

// File: rtl/mem_io_responder.sv
// Byte-wide bus responder: 128 KB RAM plus memory-mapped UART, cycle counter and program-stop.
module mem_io_responder
    import mem_io_responder_pkg::*;
#(
    parameter int unsigned RAM_ADDR_WIDTH = 17,
    parameter int unsigned TX_FIFO_DEPTH  = 8,
    parameter int unsigned TX_FULL_MARGIN = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy_in,
    input  logic [31:0] cpu_address_in,
    input  logic        cpu_rw_signal_in,
    input  logic [7:0]  cpu_data_in,
    output logic [7:0]  cpu_data_out,
    output logic        io_buffer_full_out,
    output logic        uart_tx_valid_out,
    output logic [7:0]  uart_tx_data_out,
    input  logic        uart_tx_ready_in,
    input  logic        uart_rx_valid_in,
    input  logic [7:0]  uart_rx_data_in,
    output logic        halted_out,
    output logic [1:0]  error_out
);

    logic [7:0] ram [2**RAM_ADDR_WIDTH];

    logic [RAM_ADDR_WIDTH-1:0] ram_idx;
    logic                      io_sel, wr_en, rd_en, rx_pop;
    io_reg_e                   io_reg;
    logic [7:0]                rd_data;
    logic                      tx_push, tx_overflow, halt_set;
    logic [7:0]                tx_push_data;

    logic [31:0] counter_q, snapshot_q;
    logic [7:0]  rx_data_q;
    logic        rx_full_q, halted_q, rx_overrun_q, tx_overflow_q;
    logic        unused_addr;

    assign unused_addr = ^cpu_address_in[31:18];

    assign ram_idx = cpu_address_in[RAM_ADDR_WIDTH-1:0];
    assign io_sel  = is_io(cpu_address_in[17:0]);
    assign io_reg  = io_decode(cpu_address_in[17:0]);
    assign wr_en   = rdy_in && cpu_rw_signal_in;
    assign rd_en   = rdy_in && !cpu_rw_signal_in;
    assign rx_pop  = rd_en && io_sel && (io_reg == IoUart);

    always_comb begin
        tx_push      = 1'b0;
        tx_push_data = cpu_data_in;
        halt_set     = 1'b0;
        if (wr_en && io_sel && !halted_q) begin
            unique case (io_reg)
                IoUart: tx_push = cpu_data_in != 8'h00;
                IoClk0: begin
                    // Program-stop queues a NUL so the host side sees the end of output.
                    tx_push      = 1'b1;
                    tx_push_data = 8'h00;
                    halt_set     = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_data = ram[ram_idx];
        if (io_sel) begin
            unique case (io_reg)
                IoUart:  rd_data = rx_full_q ? rx_data_q : 8'h00;
                IoClk0:  rd_data = counter_q[7:0];
                IoClk1:  rd_data = snapshot_q[15:8];
                IoClk2:  rd_data = snapshot_q[23:16];
                IoClk3:  rd_data = snapshot_q[31:24];
                default: rd_data = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !io_sel) begin
            ram[ram_idx] <= cpu_data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_data_out  <= 8'h00;
            counter_q     <= '0;
            snapshot_q    <= '0;
            rx_data_q     <= 8'h00;
            rx_full_q     <= 1'b0;
            halted_q      <= 1'b0;
            rx_overrun_q  <= 1'b0;
            tx_overflow_q <= 1'b0;
        end else if (rdy_in) begin
            counter_q <= counter_q + 32'd1;
            if (!cpu_rw_signal_in) begin
                cpu_data_out <= rd_data;
                if (io_sel && (io_reg == IoClk0)) begin
                    snapshot_q <= counter_q;
                end
            end
            if (halt_set) begin
                halted_q <= 1'b1;
            end
            if (tx_overflow) begin
                tx_overflow_q <= 1'b1;
            end
            // A new byte wins over a same-cycle pop; the pop already returned the old one.
            if (uart_rx_valid_in) begin
                rx_data_q <= uart_rx_data_in;
                rx_full_q <= 1'b1;
                if (rx_full_q && !rx_pop) begin
                    rx_overrun_q <= 1'b1;
                end
            end else if (rx_pop) begin
                rx_full_q <= 1'b0;
            end
        end
    end

    mem_io_tx_fifo #(
        .Depth      (TX_FIFO_DEPTH),
        .FullMargin (TX_FULL_MARGIN)
    ) u_tx_fifo (
        .clk_i         (clk),
        .rst_i         (rst),
        .push_i        (tx_push),
        .push_data_i   (tx_push_data),
        .pop_i         (rdy_in && uart_tx_ready_in),
        .valid_o       (uart_tx_valid_out),
        .data_o        (uart_tx_data_out),
        .almost_full_o (io_buffer_full_out),
        .overflow_o    (tx_overflow)
    );

    assign halted_out = halted_q;
    assign error_out  = {rx_overrun_q, tx_overflow_q};

endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench for mem_io_responder against a queue/array reference model.
module tb_mem_io_responder;

    localparam int DEPTH  = 8;
    localparam int MARGIN = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy_in = 1'b0;
    logic [31:0] cpu_address_in = '0;
    logic        cpu_rw_signal_in = 1'b0;
    logic [7:0]  cpu_data_in = '0;
    logic [7:0]  cpu_data_out;
    logic        io_buffer_full_out;
    logic        uart_tx_valid_out;
    logic [7:0]  uart_tx_data_out;
    logic        uart_tx_ready_in = 1'b0;
    logic        uart_rx_valid_in = 1'b0;
    logic [7:0]  uart_rx_data_in = '0;
    logic        halted_out;
    logic [1:0]  error_out;

    always #5 clk = ~clk;

    mem_io_responder #(
        .RAM_ADDR_WIDTH (17),
        .TX_FIFO_DEPTH  (DEPTH),
        .TX_FULL_MARGIN (MARGIN)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .rdy_in             (rdy_in),
        .cpu_address_in     (cpu_address_in),
        .cpu_rw_signal_in   (cpu_rw_signal_in),
        .cpu_data_in        (cpu_data_in),
        .cpu_data_out       (cpu_data_out),
        .io_buffer_full_out (io_buffer_full_out),
        .uart_tx_valid_out  (uart_tx_valid_out),
        .uart_tx_data_out   (uart_tx_data_out),
        .uart_tx_ready_in   (uart_tx_ready_in),
        .uart_rx_valid_in   (uart_rx_valid_in),
        .uart_rx_data_in    (uart_rx_data_in),
        .halted_out         (halted_out),
        .error_out          (error_out)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [7:0]  m_ram [int];
    logic [7:0]  m_txq [$];
    logic [7:0]  m_dout;
    bit          m_dout_known;
    bit          m_afull, m_halt, m_rx_full;
    logic [1:0]  m_err;
    logic [7:0]  m_rx;
    logic [31:0] m_cnt, m_snap;

    function automatic void model_reset();
        m_txq.delete();
        m_dout = 8'h00;
        m_dout_known = 1'b1;
        m_afull = 1'b0;
        m_halt = 1'b0;
        m_rx_full = 1'b0;
        m_err = 2'b00;
        m_rx = 8'h00;
        m_cnt = '0;
        m_snap = '0;
    endfunction

    // Drive one bus cycle, advance the model by the same cycle, sample #1 after the edge.
    task automatic step(input logic r, input logic [31:0] a, input logic w, input logic [7:0] d,
                        input logic tr, input logic rv, input logic [7:0] rb);
        logic [17:0] a18;
        logic [7:0]  rdv, pd;
        bit          io, pop, push, kn;
        int          idx;
        rdy_in = r;
        cpu_address_in = a;
        cpu_rw_signal_in = w;
        cpu_data_in = d;
        uart_tx_ready_in = tr;
        uart_rx_valid_in = rv;
        uart_rx_data_in = rb;
        a18 = a[17:0];
        io = (a18[17:16] == 2'b11);
        idx = int'(a[16:0]);
        pop = (m_txq.size() != 0) && tr;
        push = 1'b0;
        pd = 8'h00;
        kn = 1'b1;
        rdv = 8'h00;
        if (rst) begin
            model_reset();
        end else if (r) begin
            if (!w) begin
                if (!io) begin
                    if (m_ram.exists(idx)) rdv = m_ram[idx];
                    else kn = 1'b0;
                end else begin
                    case (a18)
                        18'h30000: begin
                            rdv = m_rx_full ? m_rx : 8'h00;
                            m_rx_full = 1'b0;
                        end
                        18'h30004: begin
                            rdv = m_cnt[7:0];
                            m_snap = m_cnt;
                        end
                        18'h30005: rdv = m_snap[15:8];
                        18'h30006: rdv = m_snap[23:16];
                        18'h30007: rdv = m_snap[31:24];
                        default:   rdv = 8'h00;
                    endcase
                end
                m_dout = rdv;
                m_dout_known = kn;
            end else begin
                if (!io) begin
                    m_ram[idx] = d;
                end else if (!m_halt) begin
                    if (a18 == 18'h30000 && d != 8'h00) begin
                        push = 1'b1;
                        pd = d;
                    end else if (a18 == 18'h30004) begin
                        push = 1'b1;
                        pd = 8'h00;
                        m_halt = 1'b1;
                    end
                end
            end
            if (pop) void'(m_txq.pop_front());
            if (push) begin
                if (m_txq.size() < DEPTH) m_txq.push_back(pd);
                else m_err[0] = 1'b1;
            end
            m_afull = m_txq.size() >= DEPTH - MARGIN;
            if (rv) begin
                if (m_rx_full) m_err[1] = 1'b1;
                m_rx = rb;
                m_rx_full = 1'b1;
            end
            m_cnt = m_cnt + 32'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 32'h0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b1, 32'h0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        step(1'b1, 32'h0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (cpu_data_out !== 8'h00 || uart_tx_valid_out !== 1'b0 || io_buffer_full_out !== 1'b0 ||
            halted_out !== 1'b0 || error_out !== 2'b00) begin
            bad++;
            $display("FAIL reset: got dout=%h valid=%b afull=%b halt=%b err=%b want 00/0/0/0/00",
                     cpu_data_out, uart_tx_valid_out, io_buffer_full_out, halted_out, error_out);
        end
    endtask

    task automatic test_ram();
        logic [31:0] addr [4];
        logic [7:0]  dat  [4];
        step(1'b1, 32'h00100, 1'b1, 8'hA5, 1'b0, 1'b0, 8'h00);
        step(1'b1, 32'h00100, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        total++;
        if (cpu_data_out !== 8'hA5) begin
            bad++;
            $display("FAIL ram_a5: got %h want a5", cpu_data_out);
        end
        for (int i = 0; i < 4; i++) begin
            addr[i] = {$urandom_range(0, 16383), 18'h0} | 32'($urandom_range(0, 18'h2FFFF));
            dat[i] = 8'($urandom);
            step(1'b1, addr[i], 1'b1, dat[i], 1'b0, 1'b0, 8'h00);
            total++;
            if (cpu_data_out !== 8'hA5) begin
                bad++;
                $display("FAIL ram_hold_on_write: got %h want a5", cpu_data_out);
            end
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, addr[i], 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
            total++;
            if (cpu_data_out !== m_dout) begin
                bad++;
                $display("FAIL ram_b2b[%0d]: got %h want %h", i, cpu_data_out, m_dout);
            end
        end
    endtask

    task automatic test_counter();
        logic [7:0] exp4 [4];
        do_reset();
        idle(100);
        exp4 = '{8'd100, 8'd0, 8'd0, 8'd0};
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 32'h30004 + 32'(k), 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
            total++;
            if (cpu_data_out !== exp4[k]) begin
                bad++;
                $display("FAIL counter_byte%0d: got %h want %h", k, cpu_data_out, exp4[k]);
            end
        end
        idle(300 + $urandom_range(0, 200));
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 32'h30004 + 32'(k), 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
            total++;
            if (cpu_data_out !== m_dout) begin
                bad++;
                $display("FAIL counter_snap%0d: got %h want %h", k, cpu_data_out, m_dout);
            end
        end
    endtask

    task automatic test_tx_fill();
        logic [7:0] seq [10];
        logic [7:0] expq [8];
        seq  = '{8'h48, 8'h69, 8'h00, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67};
        expq = '{8'h48, 8'h69, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 32'h30000, 1'b1, seq[i], 1'b0, 1'b0, 8'h00);
            total++;
            if (io_buffer_full_out !== (i >= 6) || error_out[0] !== (i == 9)) begin
                bad++;
                $display("FAIL tx_fill[%0d]: got afull=%b err0=%b want %b/%b", i,
                         io_buffer_full_out, error_out[0], (i >= 6), (i == 9));
            end
        end
        for (int k = 0; k < 8; k++) begin
            total++;
            if (uart_tx_valid_out !== 1'b1 || uart_tx_data_out !== expq[k]) begin
                bad++;
                $display("FAIL tx_drain[%0d]: got valid=%b data=%h want 1/%h", k,
                         uart_tx_valid_out, uart_tx_data_out, expq[k]);
            end
            step(1'b1, 32'h0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
        end
        total++;
        if (uart_tx_valid_out !== 1'b0 || io_buffer_full_out !== 1'b0) begin
            bad++;
            $display("FAIL tx_empty: got valid=%b afull=%b want 0/0",
                     uart_tx_valid_out, io_buffer_full_out);
        end
    endtask

    task automatic test_full_pushpop();
        do_reset();
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, 32'h30000, 1'b1, 8'($urandom_range(1, 255)), 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 32'h30000, 1'b1, 8'($urandom_range(1, 255)), 1'b1, 1'b0, 8'h00);
            total++;
            if (error_out !== 2'b00 || io_buffer_full_out !== 1'b1 || m_txq.size() != DEPTH ||
                uart_tx_data_out !== m_txq[0]) begin
                bad++;
                $display("FAIL full_pushpop[%0d]: got err=%b afull=%b data=%h want 00/1/%h", i,
                         error_out, io_buffer_full_out, uart_tx_data_out, m_txq[0]);
            end
        end
        for (int k = 0; k < DEPTH; k++) begin
            total++;
            if (uart_tx_valid_out !== 1'b1 || uart_tx_data_out !== m_txq[0]) begin
                bad++;
                $display("FAIL full_order[%0d]: got valid=%b data=%h want 1/%h", k,
                         uart_tx_valid_out, uart_tx_data_out, m_txq[0]);
            end
            step(1'b1, 32'h0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
        end
    endtask

    task automatic test_rx();
        logic [7:0] expv [6];
        expv = '{8'h41, 8'h00, 8'h44, 8'h55, 8'h22, 8'h00};
        do_reset();
        step(1'b1, 32'h0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h41);
        step(1'b1, 32'h30000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        total++;
        if (cpu_data_out !== expv[0]) begin
            bad++;
            $display("FAIL rx_first: got %h want %h", cpu_data_out, expv[0]);
        end
        step(1'b1, 32'h30000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        total++;
        if (cpu_data_out !== expv[1]) begin
            bad++;
            $display("FAIL rx_empty: got %h want %h", cpu_data_out, expv[1]);
        end
        step(1'b1, 32'h0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h44);
        step(1'b1, 32'h30000, 1'b0, 8'h00, 1'b0, 1'b1, 8'h55);
        total++;
        if (cpu_data_out !== expv[2] || error_out !== 2'b00) begin
            bad++;
            $display("FAIL rx_same_cycle: got %h err=%b want %h/00", cpu_data_out, error_out, expv[2]);
        end
        step(1'b1, 32'h30000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        total++;
        if (cpu_data_out !== expv[3]) begin
            bad++;
            $display("FAIL rx_kept: got %h want %h", cpu_data_out, expv[3]);
        end
        step(1'b1, 32'h0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h11);
        step(1'b1, 32'h0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h22);
        step(1'b1, 32'h30000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        total++;
        if (cpu_data_out !== expv[4] || error_out !== 2'b10) begin
            bad++;
            $display("FAIL rx_overrun: got %h err=%b want %h/10", cpu_data_out, error_out, expv[4]);
        end
    endtask

    task automatic test_halt_freeze();
        logic [7:0] saved;
        do_reset();
        step(1'b1, 32'h30000, 1'b1, 8'h51, 1'b0, 1'b0, 8'h00);
        step(1'b1, 32'h30004, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        saved = cpu_data_out;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 32'h30004, 1'b0, 8'h00, 1'b1, 1'b1, 8'h99);
            total++;
            if (cpu_data_out !== saved || uart_tx_valid_out !== 1'b1 || uart_tx_data_out !== 8'h51) begin
                bad++;
                $display("FAIL freeze[%0d]: got dout=%h valid=%b data=%h want %h/1/51", i,
                         cpu_data_out, uart_tx_valid_out, uart_tx_data_out, saved);
            end
        end
        step(1'b1, 32'h30004, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        total++;
        if (cpu_data_out !== saved + 8'd1) begin
            bad++;
            $display("FAIL freeze_counter: got %h want %h", cpu_data_out, saved + 8'd1);
        end
        step(1'b1, 32'h30000, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
        total++;
        if (cpu_data_out !== 8'h00 || uart_tx_valid_out !== 1'b0) begin
            bad++;
            $display("FAIL freeze_no_rx: got dout=%h valid=%b want 00/0", cpu_data_out, uart_tx_valid_out);
        end
        step(1'b1, 32'h30004, 1'b1, 8'h7E, 1'b0, 1'b0, 8'h00);
        total++;
        if (halted_out !== 1'b1 || uart_tx_valid_out !== 1'b1 || uart_tx_data_out !== 8'h00) begin
            bad++;
            $display("FAIL halt: got halt=%b valid=%b data=%h want 1/1/00",
                     halted_out, uart_tx_valid_out, uart_tx_data_out);
        end
        step(1'b1, 32'h30000, 1'b1, 8'h58, 1'b0, 1'b0, 8'h00);
        step(1'b1, 32'h30004, 1'b1, 8'h01, 1'b0, 1'b0, 8'h00);
        step(1'b1, 32'h00200, 1'b1, 8'h5A, 1'b1, 1'b0, 8'h00);
        total++;
        if (uart_tx_valid_out !== 1'b0) begin
            bad++;
            $display("FAIL halt_blocks_io: got valid=%b want 0", uart_tx_valid_out);
        end
        step(1'b1, 32'h00200, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        total++;
        if (cpu_data_out !== 8'h5A || halted_out !== 1'b1) begin
            bad++;
            $display("FAIL halt_ram: got dout=%h halt=%b want 5a/1", cpu_data_out, halted_out);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic        w;
        int          sel;
        for (int blk = 0; blk < 4; blk++) begin
            do_reset();
            for (int s = 0; s < 150; s++) begin
                sel = $urandom_range(0, 15);
                w = 1'($urandom);
                if (sel < 8) a = {14'($urandom), 18'h0} | 32'($urandom_range(0, 7)) |
                                 ($urandom_range(0, 1) ? 32'h20000 : 32'h0);
                else if (sel < 10 || sel == 15) a = 32'h30000;
                else if (sel == 10) a = 32'h30004;
                else if (sel < 14) a = 32'h30005 + 32'(sel - 11);
                else a = 32'h30008 + 32'($urandom_range(0, 100));
                if (w && a == 32'h30004 && $urandom_range(0, 9) != 0) a = 32'h30000;
                step($urandom_range(0, 99) < 85, a, w, 8'($urandom_range(0, 3) == 0 ? 0 : $urandom),
                     1'($urandom), $urandom_range(0, 3) == 0, 8'($urandom));
                if (m_dout_known) begin
                    total++;
                    if (cpu_data_out !== m_dout) begin
                        bad++;
                        $display("FAIL rnd_dout[%0d.%0d]: got %h want %h", blk, s, cpu_data_out, m_dout);
                    end
                end
                total++;
                if (uart_tx_valid_out !== (m_txq.size() != 0) || io_buffer_full_out !== m_afull ||
                    halted_out !== m_halt || error_out !== m_err) begin
                    bad++;
                    $display("FAIL rnd_flags[%0d.%0d]: got v=%b af=%b h=%b e=%b want %b/%b/%b/%b",
                             blk, s, uart_tx_valid_out, io_buffer_full_out, halted_out, error_out,
                             (m_txq.size() != 0), m_afull, m_halt, m_err);
                end
                if (m_txq.size() != 0) begin
                    total++;
                    if (uart_tx_data_out !== m_txq[0]) begin
                        bad++;
                        $display("FAIL rnd_txdata[%0d.%0d]: got %h want %h", blk, s,
                                 uart_tx_data_out, m_txq[0]);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_ram();
        test_counter();
        test_tx_fill();
        test_full_pushpop();
        test_rx();
        test_random();
        test_halt_freeze();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
- Responder (target) side of the CPU's byte-wide memory bus: data in/out, 32-bit address, write/read strobe, io_buffer_full.
- Contains the 128 KB RAM and the memory-mapped I/O region (mem_a[17:16]==2'b11): UART tx/rx byte port, cycle counter, program-stop.
- Sits between the cpu top and the UART/board shell; replaces ad-hoc RAM/IO glue.

Parameters:
- RAM_ADDR_WIDTH, 17, RAM byte-address width (2^17 bytes).
- TX_FIFO_DEPTH, 8, UART tx FIFO entries (power of two, >=4).
- TX_FULL_MARGIN, 2, free entries below which io_buffer_full_out asserts.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy_in  in  1  global enable; low freezes all state
- cpu_address_in  in  32  bus address (bits 17:0 decoded)
- cpu_rw_signal_in  in  1  1 = write, 0 = read
- cpu_data_in  in  8  write data from CPU
- cpu_data_out  out  8  read data, valid the cycle after the address
- io_buffer_full_out  out  1  tx FIFO nearly full
- uart_tx_valid_out  out  1  tx FIFO head valid
- uart_tx_data_out  out  8  tx FIFO head byte
- uart_tx_ready_in  in  1  UART accepts head this cycle
- uart_rx_valid_in  in  1  received byte strobe
- uart_rx_data_in  in  8  received byte
- halted_out  out  1  sticky, set by program-stop write
- error_out  out  2  sticky {rx_overrun, tx_overflow}

Behaviour:
- Reset: cpu_data_out=0, tx FIFO empty, uart_tx_valid_out=0, io_buffer_full_out=0, cycle counter=0, snapshot=0, rx holding register empty, halted_out=0, error_out=0. RAM contents are not cleared. Reset mid-transfer discards queued tx bytes and the pending read.
- Decode: io = addr[17:16]==2'b11; otherwise RAM index = addr[RAM_ADDR_WIDTH-1:0].
- rdy_in low: no RAM write, no FIFO push or pop, counter held, cpu_data_out held. UART tx pop on uart_tx_ready_in is also suppressed.
- RAM read: cpu_data_out <= ram[idx] at the clock edge, so data is visible one cycle after the address. Back-to-back reads give one byte per cycle.
- RAM write: ram[idx] <= cpu_data_in at the edge. cpu_data_out is held on write cycles.
- IO read 0x30000: returns the rx holding byte and clears it; returns 0x00 if empty.
- IO read 0x30004: returns counter[7:0] and latches a snapshot of the full counter.
- IO read 0x30005..0x30007: return snapshot bytes 1..3, so a multi-byte read is coherent.
- Other IO reads return 0x00.
- IO write 0x30000: pushes cpu_data_in to the tx FIFO. A 0x00 byte is ignored.
- IO write 0x30004: pushes 0x00 to the tx FIFO (forced), sets halted_out, and blocks all later IO writes. RAM writes still proceed.
- Writes to other IO addresses are ignored.
- Cycle counter: 32-bit, +1 every clk with rdy_in high, wraps at 2^32.
- tx FIFO:
  - Circular buffer with count register; uart_tx_valid_out = count!=0.
  - Pop when uart_tx_valid_out && uart_tx_ready_in.
  - Push and pop in the same cycle: count unchanged, both take effect (including when full).
  - Push when full with no pop: byte dropped, error_out[0] set.
  - io_buffer_full_out registered = (count_next >= TX_FIFO_DEPTH-TX_FULL_MARGIN). The margin absorbs CPU request lag.
- rx register:
  - uart_rx_valid_in loads the byte and sets full.
  - Arrival in the same cycle as a pop: the pop returns the old byte, the new byte is stored.
  - Arrival while full with no pop: overwrite and set error_out[1].
- Read and write never both target the bus in one cycle; cpu_rw_signal_in selects.

Decomposition:
- Shared package/header: IO_BASE 0x30000, IO_UART_ADDR 0x30000, IO_CLK_ADDR 0x30004, IO select bits [17:16]=2'b11.
- Sub-module: mem_io_tx_fifo (parameterised depth; push/pop/count/almost-full).
- RAM array, decode, rx register and counter stay in the top.

Test Plan:
- Write 0xA5 to 0x00100, then read 0x00100 → cpu_data_out==0xA5 exactly one cycle after the read address.
- Reset, hold rdy_in high 100 cycles, read 0x30004..0x30007 over 4 cycles → bytes form 100+k (k = cycle offset at the 0x30004 read) and stay coherent despite counter advance.
- uart_tx_ready_in=0, write 'H','i',0x00,... to 0x30000 → 0x00 not queued; io_buffer_full_out asserts at 6 entries; 9th push sets error_out[0].
- Full FIFO with simultaneous push and pop (ready=1) → count stays 8, no overflow, FIFO order preserved.
- uart_rx_valid_in with 0x41 then read 0x30000 → 0x41; immediate second read → 0x00; two arrivals without a read → error_out[1]=1.
- Write 0x30004 → tx FIFO gets 0x00, halted_out=1; a later write of 'X' to 0x30000 is not queued. Drop rdy_in for 5 cycles → counter and outputs frozen.
